decode_regfile_unit: RTL and testbench

Instruction-decode stage of the 16-bit pipelined CPU. It combines the combinational instruction decoder with the 8×16-bit general-purpose register file. The block sits between the fetch latch and the execute stage: it turns one 16-bit instruction into control fields and the two source-operand values, and it accepts one register write-back per clock from the writeback stage.

---
 rtl/decode_regfile_unit.sv | 140 ++++++++++++++
 tb/tb_decode_regfile_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile_unit.sv
// ---------------------------------------------------------------------------
// decode_regfile_unit
// Instruction-decode stage of the 16-bit pipelined CPU: a purely
// combinational instruction decoder feeding the read addresses of an
// 8 x 16-bit general-purpose register file.  The register file takes one
// write-back per clock and clears asynchronously on an active-low reset.
// Decode fields are combinational by design (zero-cycle latency), so they
// are not registered; only the register file holds state.
// ---------------------------------------------------------------------------
module decode_regfile_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic [1:0]  instr_class,
    output logic [4:0]  alu_ctrl,
    output logic [2:0]  reg_dst,
    output logic [2:0]  reg_rs1,
    output logic [2:0]  reg_rs2,
    output logic [15:0] imm_se,
    output logic        reg_write,
    output logic        alu_src_imm,
    output logic        mem_write,
    output logic        reg_write_back_sel,
    output logic [2:0]  jump_ctrl,
    output logic [15:0] rs1_data,
    output logic [15:0] rs2_data
);

    // Instruction classes held in instr[15:14]
    localparam logic [1:0] CLASS_RTYPE = 2'b00;
    localparam logic [1:0] CLASS_ITYPE = 2'b01;
    localparam logic [1:0] CLASS_MEM   = 2'b10;
    localparam logic [1:0] CLASS_JUMP  = 2'b11;

    // ALU code used by loads/stores to form base + offset
    localparam logic [4:0] ALU_ADD     = 5'b00000;

    // Sign-extend the 6-bit I-type immediate to the datapath width
    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    // Sign-extend the 7-bit memory offset to the datapath width
    function automatic logic [15:0] sext7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

    logic [15:0] regs_q [0:7];
    logic [15:0] regs_d [0:7];

    // Decode the instruction into control fields; unused fields stay zero
    always_comb begin
        instr_class        = instr[15:14];
        alu_ctrl           = 5'd0;
        reg_dst            = 3'd0;
        reg_rs1            = 3'd0;
        reg_rs2            = 3'd0;
        imm_se             = 16'h0000;
        reg_write          = 1'b0;
        alu_src_imm        = 1'b0;
        mem_write          = 1'b0;
        reg_write_back_sel = 1'b0;
        jump_ctrl          = 3'd0;
        case (instr[15:14])
            CLASS_RTYPE: begin
                alu_ctrl  = instr[13:9];
                reg_dst   = instr[8:6];
                reg_rs1   = instr[5:3];
                reg_rs2   = instr[2:0];
                reg_write = 1'b1;
            end
            CLASS_ITYPE: begin
                alu_ctrl    = instr[13:9];
                reg_dst     = instr[8:6];
                reg_rs1     = instr[8:6];
                imm_se      = sext6(instr[5:0]);
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
            end
            CLASS_MEM: begin
                alu_ctrl    = ALU_ADD;
                reg_rs1     = instr[9:7];
                imm_se      = sext7(instr[6:0]);
                alu_src_imm = 1'b1;
                if (instr[13]) begin
                    // store: [12:10] names the register holding store data
                    reg_rs2   = instr[12:10];
                    mem_write = 1'b1;
                end else begin
                    // load: [12:10] names the destination, data comes from memory
                    reg_dst            = instr[12:10];
                    reg_write          = 1'b1;
                    reg_write_back_sel = 1'b1;
                end
            end
            CLASS_JUMP: begin
                // bits [4:0] are don't-care for jumps
                jump_ctrl = instr[13:11];
                reg_rs1   = instr[10:8];
                reg_rs2   = instr[7:5];
            end
            default: begin
                instr_class = instr[15:14];
            end
        endcase
    end

    // Compute the next register-file state from the write-back port
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end else begin
            regs_d[wr_addr] = regs_q[wr_addr];
        end
    end

    // Register file storage with asynchronous clear on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Combinational read ports; no bypass of a same-cycle write
    always_comb begin
        rs1_data = regs_q[reg_rs1];
        rs2_data = regs_q[reg_rs2];
    end

endmodule

// File: tb/tb_decode_regfile_unit.sv
// ---------------------------------------------------------------------------
// Self-checking bench for decode_regfile_unit.  Expected values come from
// the documented decode examples and from a behavioural model (an array of
// eight words plus a rule-based decode function).
// ---------------------------------------------------------------------------
module tb_decode_regfile_unit;

    logic        clk;
    logic        clk_on;
    logic        rst;
    logic [15:0] instr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  instr_class;
    logic [4:0]  alu_ctrl;
    logic [2:0]  reg_dst;
    logic [2:0]  reg_rs1;
    logic [2:0]  reg_rs2;
    logic [15:0] imm_se;
    logic        reg_write;
    logic        alu_src_imm;
    logic        mem_write;
    logic        reg_write_back_sel;
    logic [2:0]  jump_ctrl;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model [8];

    typedef struct packed {
        logic [1:0]  cls;
        logic [4:0]  alu;
        logic [2:0]  dst;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
        logic        rw;
        logic        asi;
        logic        mw;
        logic        wbs;
        logic [2:0]  jc;
    } dec_t;

    decode_regfile_unit dut (
        .clk                (clk),
        .rst                (rst),
        .instr              (instr),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .instr_class        (instr_class),
        .alu_ctrl           (alu_ctrl),
        .reg_dst            (reg_dst),
        .reg_rs1            (reg_rs1),
        .reg_rs2            (reg_rs2),
        .imm_se             (imm_se),
        .reg_write          (reg_write),
        .alu_src_imm        (alu_src_imm),
        .mem_write          (mem_write),
        .reg_write_back_sel (reg_write_back_sel),
        .jump_ctrl          (jump_ctrl),
        .rs1_data           (rs1_data),
        .rs2_data           (rs2_data)
    );

    // Clock runs only once clk_on is raised, so reset can be checked edge-free
    always begin
        wait (clk_on);
        #5 clk = ~clk;
    end

    // Signed integer value of the low n bits of v, then wrapped to 16 bits
    function automatic logic [15:0] sext_val(input logic [15:0] v, input int n);
        int x;
        x = int'(v) & ((1 << n) - 1);
        if (x >= (1 << (n - 1))) x = x - (1 << n);
        return 16'(x);
    endfunction

    // Reference decoder written from the instruction-format rules
    function automatic dec_t ref_decode(input logic [15:0] ins);
        dec_t d;
        d = '0;
        d.cls = ins[15:14];
        if (d.cls == 2'd0) begin
            d.alu = ins[13:9]; d.dst = ins[8:6]; d.rs1 = ins[5:3]; d.rs2 = ins[2:0];
            d.rw  = 1'b1;
        end else if (d.cls == 2'd1) begin
            d.alu = ins[13:9]; d.dst = ins[8:6]; d.rs1 = ins[8:6];
            d.imm = sext_val(ins, 6);
            d.rw  = 1'b1; d.asi = 1'b1;
        end else if (d.cls == 2'd2) begin
            d.rs1 = ins[9:7]; d.imm = sext_val(ins, 7); d.asi = 1'b1;
            if (ins[13] == 1'b0) begin
                d.dst = ins[12:10]; d.rw = 1'b1; d.wbs = 1'b1;
            end else begin
                d.rs2 = ins[12:10]; d.mw = 1'b1;
            end
        end else begin
            d.jc = ins[13:11]; d.rs1 = ins[10:8]; d.rs2 = ins[7:5];
        end
        return d;
    endfunction

    function automatic dec_t dut_fields();
        return {instr_class, alu_ctrl, reg_dst, reg_rs1, reg_rs2, imm_se,
                reg_write, alu_src_imm, mem_write, reg_write_back_sel, jump_ctrl};
    endfunction

    function automatic logic [15:0] rd_instr(input logic [2:0] a, input logic [2:0] b);
        return {2'b00, 5'd0, 3'd0, a, b};
    endfunction

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000; instr = 16'h0000;
        #2 rst = 1'b0;
        #1;
        for (int a = 0; a < 8; a++) begin
            instr = rd_instr(3'(a), 3'(a));
            #1;
            checks++;
            if (rs1_data !== 16'h0000 || rs2_data !== 16'h0000) begin
                failures++;
                $display("FAIL reset_read r%0d: got rs1=%h rs2=%h want 0000", a, rs1_data, rs2_data);
            end
        end
        clk_on = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
        @(posedge clk); #1;
        instr = rd_instr(3'd5, 3'd5);
        #1;
        checks++;
        if (rs1_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_write_ignored: got %h want 0000", rs1_data);
        end
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    endtask

    task automatic test_decode_examples();
        logic [15:0] ins [6];
        dec_t        exp [6];
        dec_t        got;
        ins[0] = 16'h069C; exp[0] = '{2'd0, 5'd3, 3'd2, 3'd3, 3'd4, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        ins[1] = 16'h407E; exp[1] = '{2'd1, 5'd0, 3'd1, 3'd1, 3'd0, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        ins[2] = 16'hB503; exp[2] = '{2'd2, 5'd0, 3'd0, 3'd2, 3'd5, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        ins[3] = 16'h8503; exp[3] = '{2'd2, 5'd0, 3'd1, 3'd2, 3'd0, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0};
        ins[4] = 16'hD3C0; exp[4] = '{2'd3, 5'd0, 3'd0, 3'd3, 3'd6, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
        ins[5] = 16'h0000; exp[5] = '{2'd0, 5'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        for (int i = 0; i < 6; i++) begin
            instr = ins[i];
            #1;
            got = dut_fields();
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL decode_example instr=%h: got %h want %h", ins[i], got, exp[i]);
            end
        end
    endtask

    task automatic test_decode_random();
        dec_t got;
        dec_t exp;
        for (int i = 0; i < 400; i++) begin
            instr = 16'($urandom);
            #1;
            got = dut_fields();
            exp = ref_decode(instr);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL decode_random instr=%h: got %h want %h", instr, got, exp);
            end
        end
    endtask

    task automatic test_regfile_directed();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'hBEEF;
        @(posedge clk); model[6] = 16'hBEEF;
        @(negedge clk);
        wr_addr = 3'd3; wr_data = 16'h0000;
        @(posedge clk); model[3] = 16'h0000;
        @(negedge clk);
        wr_en = 1'b0;
        instr = rd_instr(3'd3, 3'd6);
        #1;
        checks++;
        if (rs1_data !== 16'h0000 || rs2_data !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_read: got rs1=%h rs2=%h want 0000 beef", rs1_data, rs2_data);
        end
        // same-cycle write and read of R6 on both ports
        @(negedge clk);
        instr = rd_instr(3'd6, 3'd6);
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h1111;
        #1;
        checks++;
        if (rs1_data !== 16'hBEEF || rs2_data !== 16'hBEEF) begin
            failures++;
            $display("FAIL same_cycle_before: got rs1=%h rs2=%h want beef", rs1_data, rs2_data);
        end
        @(posedge clk); model[6] = 16'h1111;
        #1;
        checks++;
        if (rs1_data !== 16'h1111 || rs2_data !== 16'h1111) begin
            failures++;
            $display("FAIL same_cycle_after: got rs1=%h rs2=%h want 1111", rs1_data, rs2_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        dec_t d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_addr = 3'($urandom);
            wr_data = 16'($urandom);
            instr   = 16'($urandom);
            #1;
            d = ref_decode(instr);
            checks++;
            if (rs1_data !== model[d.rs1] || rs2_data !== model[d.rs2]) begin
                failures++;
                $display("FAIL b2b_read instr=%h: got rs1=%h rs2=%h want %h %h",
                         instr, rs1_data, rs2_data, model[d.rs1], model[d.rs2]);
            end
            @(posedge clk);
            if (wr_en) model[wr_addr] = wr_data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_midop_reset();
        dec_t got;
        // fill every register with a nonzero value first
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 3'(a); wr_data = 16'h5A00 | 16'(a);
            @(posedge clk); model[a] = 16'h5A00 | 16'(a);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int a = 0; a < 8; a++) begin
            instr = rd_instr(3'(a), 3'((a + 1) % 8));
            #0.5;
            checks++;
            if (rs1_data !== 16'h0000 || rs2_data !== 16'h0000) begin
                failures++;
                $display("FAIL midop_reset r%0d: got rs1=%h rs2=%h want 0000", a, rs1_data, rs2_data);
            end
        end
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        // decode is unaffected by reset
        instr = 16'hB503;
        #0.5;
        got = dut_fields();
        checks++;
        if (got !== ref_decode(16'hB503)) begin
            failures++;
            $display("FAIL decode_in_reset: got %h want %h", got, ref_decode(16'hB503));
        end
        // first write after release lands on the first edge with rst high
        @(negedge clk);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hC0DE;
        instr = rd_instr(3'd2, 3'd7);
        @(posedge clk); model[2] = 16'hC0DE;
        #1;
        checks++;
        if (rs1_data !== 16'hC0DE || rs2_data !== 16'h0000) begin
            failures++;
            $display("FAIL first_write_after_reset: got rs1=%h rs2=%h want c0de 0000", rs1_data, rs2_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        clk    = 1'b0;
        clk_on = 1'b0;
        test_reset();
        test_decode_examples();
        test_decode_random();
        test_regfile_directed();
        test_back_to_back();
        test_midop_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
